// File: rtl/kernel_loader_if.sv
// ---------------------------------------------------------------------------
// kernel_loader_if : stream input, swap handshake and buffer-side outputs
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface kernel_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int UNITS      = 10
);
  logic                        s_valid;
  logic [DATA_WIDTH-1:0]       s_data;
  logic                        s_last;
  logic                        s_ready;
  logic                        swap_ready;
  logic                        buff_en;
  logic [DATA_WIDTH*UNITS-1:0] x_out;
  logic                        err_last;

  modport master (
    output s_valid, s_data, s_last, swap_ready,
    input  s_ready, buff_en, x_out, err_last
  );

  modport slave (
    input  s_valid, s_data, s_last, swap_ready,
    output s_ready, buff_en, x_out, err_last
  );
endinterface

`default_nettype wire

// File: rtl/kernel_loader.sv
// ---------------------------------------------------------------------------
// kernel_loader : assembles UNITS stream words into one vector, strobes buff_en
//                 on swap. Option macro: KERNEL_LOADER_LAST_CHECK_EN
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module kernel_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int UNITS      = 10
) (
  input  wire logic       clk,
  input  wire logic       rst,
  kernel_loader_if.slave  bus
);

  localparam int                 IDX_W    = $clog2(UNITS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(UNITS - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_FULL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DATA_WIDTH*UNITS-1:0] x_q, x_d;
  logic                        accept;
  logic                        at_last;

  assign accept  = (state_q == S_FILL) && bus.s_valid;
  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          for (int i = 0; i < UNITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              x_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
            end
          end
          if (at_last) begin
            idx_d   = '0;
            state_d = S_FULL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (bus.swap_ready) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_FILL;
      default:  state_d = S_FILL;
    endcase
  end

  // Handshake outputs decode registered state only; no input feeds through.
  assign bus.s_ready = (state_q == S_FILL);
  assign bus.buff_en = (state_q == S_COMMIT);
  assign bus.x_out   = x_q;

`ifdef KERNEL_LOADER_LAST_CHECK_EN
  logic err_q, err_d;

  // s_last must coincide exactly with the final lane; framing never alters sequencing.
  assign err_d = err_q | (accept && (bus.s_last != at_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_last = err_q;
`else
  logic w_unused_last;
  assign w_unused_last = bus.s_last;
  assign bus.err_last  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kernel_loader.sv
// ---------------------------------------------------------------------------
// tb_kernel_loader : directed vector table plus hand-written corner sequences
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_kernel_loader;

  localparam int DW = 16;
  localparam int UN = 10;
  localparam int W  = DW * UN;

`ifdef KERNEL_LOADER_LAST_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kernel_loader_if #(.DATA_WIDTH(DW), .UNITS(UN)) bus ();

  kernel_loader #(.DATA_WIDTH(DW), .UNITS(UN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [DW-1:0] data;
    logic          last;
    logic          swap;
    logic          exp_ready;
    logic          exp_ben;
    logic [W-1:0]  exp_x;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] seq_vec(input int base, input int n);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && n < 40) begin
      tick();
      n++;
    end
    chk("push_ready", W'(bus.s_ready), W'(1));
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    tick();
    chk("rst_ready", W'(bus.s_ready), W'(1));
    chk("rst_ben",   W'(bus.buff_en), W'(0));
    chk("rst_x",     bus.x_out, '0);
    chk("rst_err",   W'(bus.err_last), W'(0));
    rst = 1'b0;
  endtask

  task automatic wait_ben(input string name, input logic [W-1:0] exp_x);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (bus.buff_en) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_ben"}, W'(found), W'(1));
    chk({name, "_x"}, bus.x_out, exp_x);
    tick();
    chk({name, "_ben_off"}, W'(bus.buff_en), W'(0));
  endtask

  initial begin
    logic [W-1:0] v;

    rst            = 1'b1;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.s_last     = 1'b0;
    bus.swap_ready = 1'b0;
    tick();

    // Basic stream: reset row, words 1..10, commit, return to FILL, first word of next vector.
    tbl[0] = '{1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, '0};
    for (int r = 1; r <= 10; r++)
      tbl[r] = '{1'b0, 1'b1, DW'(r), (r == 10), 1'b1, (r != 10), 1'b0, seq_vec(1, r)};
    tbl[11] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, seq_vec(1, 10)};
    tbl[12] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, seq_vec(1, 10)};
    v = seq_vec(1, 10);
    v[DW-1:0] = 16'h0055;
    tbl[13] = '{1'b0, 1'b1, 16'h0055, 1'b0, 1'b1, 1'b1, 1'b0, v};

    for (int r = 0; r < 14; r++) begin
      rst            = tbl[r].rst;
      bus.s_valid    = tbl[r].vld;
      bus.s_data     = tbl[r].data;
      bus.s_last     = tbl[r].last;
      bus.swap_ready = tbl[r].swap;
      tick();
      chk($sformatf("tbl%0d_ready", r), W'(bus.s_ready), W'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d_ben", r),   W'(bus.buff_en), W'(tbl[r].exp_ben));
      chk($sformatf("tbl%0d_x", r),     bus.x_out, tbl[r].exp_x);
      chk($sformatf("tbl%0d_err", r),   W'(bus.err_last), W'(0));
    end
    bus.s_valid = 1'b0;

    // Swap stall: FULL must hold for 20 cycles, commit exactly one cycle after swap_ready.
    do_reset();
    bus.swap_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push(DW'(16'h200 + i), i == 10);
    for (int c = 0; c < 20; c++) begin
      chk("stall_ready", W'(bus.s_ready), W'(0));
      chk("stall_ben",   W'(bus.buff_en), W'(0));
      chk("stall_x",     bus.x_out, seq_vec(16'h201, 10));
      tick();
    end
    bus.swap_ready = 1'b1;
    tick();
    chk("swap_ben", W'(bus.buff_en), W'(1));
    chk("swap_ready_low", W'(bus.s_ready), W'(0));
    bus.swap_ready = 1'b0;
    tick();
    chk("swap_ben_off", W'(bus.buff_en), W'(0));
    chk("swap_ready_hi", W'(bus.s_ready), W'(1));

    // Bubbles, then a word held valid through FULL/COMMIT must land once in lane 0.
    do_reset();
    bus.swap_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      push(DW'(16'h300 + i), i == 10);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hAAAA;
    chk("bp_full_ready", W'(bus.s_ready), W'(0));
    chk("bp_full_x", bus.x_out, seq_vec(16'h301, 10));
    tick();
    chk("bp_commit_ben", W'(bus.buff_en), W'(1));
    chk("bp_commit_ready", W'(bus.s_ready), W'(0));
    tick();
    chk("bp_fill_ready", W'(bus.s_ready), W'(1));
    chk("bp_fill_x", bus.x_out, seq_vec(16'h301, 10));
    tick();
    bus.s_valid = 1'b0;
    v = seq_vec(16'h301, 10);
    v[DW-1:0] = 16'hAAAA;
    chk("bp_lane0", bus.x_out, v);
    tick();
    chk("bp_once", bus.x_out, v);
    for (int i = 1; i <= 9; i++) push(DW'(16'h400 + i), i == 9);
    v = seq_vec(16'h400, 10);
    v[DW-1:0] = 16'hAAAA;
    wait_ben("bp_vec", v);

    // Mid-fill reset discards the partial vector.
    do_reset();
    bus.swap_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(DW'(16'h500 + i), 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_x", bus.x_out, '0);
    chk("mid_rst_ben", W'(bus.buff_en), W'(0));
    chk("mid_rst_ready", W'(bus.s_ready), W'(1));
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) push(DW'(16'h600 + i), i == 10);
    wait_ben("mid_vec", seq_vec(16'h601, 10));

    // Framing error: s_last on word 5.
    do_reset();
    bus.swap_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push(DW'(16'h700 + i), i == 5);
      if (i == 4) chk("err_before", W'(bus.err_last), W'(0));
      if (i == 5) chk("err_set", W'(bus.err_last), W'(ERR_EXP));
    end
    wait_ben("err_vec", seq_vec(16'h701, 10));
    for (int i = 1; i <= 10; i++) push(DW'(16'h800 + i), i == 10);
    wait_ben("err_vec2", seq_vec(16'h801, 10));
    chk("err_sticky", W'(bus.err_last), W'(ERR_EXP));
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
